audio_cmd_arbiter: RTL

//  Shares the Audio_Controller command write port (cs/rw/data) among NUM_REQ game-side sound requesters.

---
 rtl/audio_cmd_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/audio_cmd_arbiter.sv
// Audio command arbiter: latches one pending command per requester and issues them one at a time
// on the Audio_Controller write port, with a HOLDOFF-cycle gap. Define AUDIO_ARB_RR_EN for round-robin.
module audio_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int HOLDOFF = 64,
    parameter int CMD_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] cmd_in,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       pend,
    output logic                     aud_cs,
    output logic                     aud_rw,
    output logic [CMD_W-1:0]         aud_data,
    output logic [7:0]               drop_cnt
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               aud_cs_q, aud_cs_d;
    logic               aud_rw_q, aud_rw_d;
    logic [CMD_W-1:0]   aud_data_q, aud_data_d;
    logic [7:0]         drop_q, drop_d;
    logic [CMD_W-1:0]   slot_q [NUM_REQ];
    logic [CMD_W-1:0]   slot_d [NUM_REQ];
    logic [CMD_W-1:0]   cmd_arr [NUM_REQ];
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [3:0]         n_drop;
    logic [8:0]         drop_sum;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cmd_arr[k] = cmd_in[k*CMD_W +: CMD_W];
        end
    end

`ifdef AUDIO_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // First pass covers indices after the last grant, second pass wraps to the low end.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && pend_q[k] && (IDX_W'(k) > ptr_q)) begin
                sel_idx   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && pend_q[k]) begin
                sel_idx   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && pend_q[k]) begin
                sel_idx   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        pend_d     = pend_q;
        slot_d     = slot_q;
        ack_d      = '0;
        aud_cs_d   = 1'b0;
        aud_rw_d   = 1'b1;
        aud_data_d = aud_data_q;
        n_drop     = '0;
`ifdef AUDIO_ARB_RR_EN
        ptr_d      = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d         = ISSUE;
                    win_d           = sel_idx;
                    ack_d[sel_idx]  = 1'b1;
                    aud_cs_d        = 1'b1;
                    aud_rw_d        = 1'b0;
                    // A same-cycle overwrite of the winner goes out with the new value
                    aud_data_d      = req[sel_idx] ? cmd_arr[sel_idx] : slot_q[sel_idx];
`ifdef AUDIO_ARB_RR_EN
                    ptr_d           = sel_idx;
`endif
                end
            end
            ISSUE: begin
                state_d        = HOLD;
                cnt_d          = CNT_W'(HOLDOFF - 1);
                pend_d[win_q]  = 1'b0;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Latching after the issue-clear lets a new request win over the clear
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                slot_d[i] = cmd_arr[i];
                pend_d[i] = 1'b1;
                if (pend_q[i] && !((state_q == ISSUE) && (win_q == IDX_W'(i)))) begin
                    n_drop = n_drop + 1'b1;
                end
            end
        end

        drop_sum = {1'b0, drop_q} + {5'd0, n_drop};
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= '0;
            pend_q     <= '0;
            ack_q      <= '0;
            aud_cs_q   <= 1'b0;
            aud_rw_q   <= 1'b1;
            aud_data_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            aud_cs_q   <= aud_cs_d;
            aud_rw_q   <= aud_rw_d;
            aud_data_q <= aud_data_d;
            drop_q     <= drop_d;
        end
    end

    // Command slots are pure data; pend_q qualifies them
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign ack      = ack_q;
    assign pend     = pend_q;
    assign aud_cs   = aud_cs_q;
    assign aud_rw   = aud_rw_q;
    assign aud_data = aud_data_q;
    assign drop_cnt = drop_q;

endmodule
